spi_buffer_drain: RTL
=====================

# spi_buffer_drain

SPI-master transmitter that empties the 32-byte serial receive buffer onto the SPI bus. It waits for the buffer's FULL flag, then reads the buffer byte by byte using the buffer's ADDR/READ port. Each byte is shifted out MSB-first in SPI mode 0, and all bytes go out within a single chip-select frame. When the frame is finished, it pulses a clear request so the buffer can refill from the serial side.

## Interface
- CLK_DIV, 4, system clocks per SCLK half-period; legal values are 1 or more.
- NBYTES, 32, bytes per frame; legal range is 1..32.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FULL  in  1  buffer-full flag from the byte buffer.
- BYTEIN  in  8  byte returned by the buffer for the presented ADDR.
- ADDR  out  5  buffer read address.
- READ  out  1  buffer read strobe; one-cycle pulse, and the buffer latches on its rising edge.
- BUF_CLR  out  1  one-cycle request to clear the buffer; the integrator inverts it onto the buffer's active-low reset.
- SCLK  out  1  SPI clock; idles low.
- MOSI  out  1  SPI data.
- CS_N  out  1  SPI chip select, active-low.
- BUSY  out  1  high whenever the block is not in IDLE.
- DONE  out  1  one-cycle pulse at the end of a frame.

## Operation
- All outputs are registered.
- Reset values: ADDR=0, READ=0, BUF_CLR=0, SCLK=0, MOSI=0, CS_N=1, BUSY=0, DONE=0, internal ARMED=0, state=IDLE.
- **ARMED**: set whenever FULL is sampled 0 in IDLE; cleared when a frame starts. This blocks a restart on a stale FULL.
- **IDLE**
  - If FULL=1 and ARMED=1: go to FETCH and set CS_N<=0, ADDR<=0, READ<=1, BUSY<=1.
  - DONE and BUF_CLR are forced to 0 in IDLE.
- **FETCH** (1 cycle): READ<=0, then go to LATCH.
- **LATCH** (1 cycle): shift register<=BYTEIN, MOSI<=BYTEIN[7], divider<=0, bit count<=0, then go to SHIFT.
- **SHIFT**
  - The divider counts 0..CLK_DIV-1; on the terminal count SCLK toggles and the divider wraps to 0.
  - On a falling toggle with bit count <7: bit count increments and MOSI takes the next lower bit.
  - On the falling toggle of bit 7: go to NEXT.
- **NEXT**
  - If ADDR==NBYTES-1: go to FINISH.
  - Otherwise: ADDR<=ADDR+1, READ<=1, go to FETCH.
- **FINISH** (1 cycle): CS_N<=1, DONE<=1, BUF_CLR<=1, MOSI<=0, then go to IDLE (where BUSY<=0).
- CS_N stays low continuously from FETCH of byte 0 to FINISH. Between bytes, SCLK holds low for 3 cycles (NEXT, FETCH, LATCH).
- FULL falling mid-frame is ignored; the frame always completes all NBYTES bytes.
- RESET asserted mid-frame returns every output to its reset value immediately. No DONE or BUF_CLR is issued, and the buffer contents are untouched.

## Timing
- Start latency: CS_N falls, READ rises and ADDR=0 on the first CLK edge where FULL=1 and ARMED=1 are sampled in IDLE.
- BYTEIN is sampled exactly 1 cycle after the READ pulse, in LATCH.
- SCLK period = 2*CLK_DIV cycles. For each bit, MOSI is stable CLK_DIV cycles before the SCLK rise and CLK_DIV cycles after it.
- The first SCLK rise occurs CLK_DIV cycles after LATCH.
- Cycles per byte in SHIFT = 16*CLK_DIV.
- CS_N-low duration = NBYTES*(2+16*CLK_DIV) + NBYTES.
  - NBYTES=32, CLK_DIV=4: 2144 cycles.
  - NBYTES=32, CLK_DIV=2: 1120 cycles.
- DONE and BUF_CLR are high for exactly the 1 cycle after CS_N rises' edge (FINISH). BUSY falls 1 cycle later.
- Earliest restart is 2 cycles after FINISH, and only once FULL has been seen 0 in IDLE.

## Test plan
- **Reset**: assert RESET at random mid-SHIFT points -> same cycle: CS_N=1, SCLK=0, MOSI=0, READ=0, ADDR=0, BUSY=0, DONE=0, BUF_CLR=0.
- **Full frame** (CLK_DIV=2; buffer model holds 0xA5, 0x01, ..., 0x1F; FULL low then high):
  - An SPI mode-0 slave model captures the same 32 bytes MSB-first.
  - ADDR steps 0..31 with one READ pulse each.
  - CS_N stays low for exactly 1120 cycles.
  - DONE and BUF_CLR pulse once.
- **Bit timing** (CLK_DIV=4, byte 0x80 then 0x01) -> SCLK high and low for 4 cycles each; MOSI changes only on falling SCLK; the first rise comes 4 cycles after LATCH.
- **Stale FULL**: FULL held high after DONE (model ignores BUF_CLR) -> no second frame; FULL low for 1 cycle then high -> new frame starts at ADDR=0.
- **Mid-frame reset** during byte 10, then release with FULL high -> no frame until FULL is seen 0 then 1; the new frame restarts at ADDR=0 and emits all 32 bytes.
- **FULL dropped mid-frame** at byte 5 -> frame still completes all 32 bytes, CS_N-low duration is unchanged, and DONE pulses once.

Source files
------------

// File: rtl/spi_buffer_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_buffer_drain_if
//  Description : Buffer read port plus SPI master pins of the buffer drainer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_buffer_drain_if;
  logic       full;
  logic [7:0] byte_in;
  logic [4:0] addr;
  logic       read;
  logic       buf_clr;
  logic       sclk;
  logic       mosi;
  logic       cs_n;
  logic       busy;
  logic       done;

  modport master (
    input  full, byte_in,
    output addr, read, buf_clr, sclk, mosi, cs_n, busy, done
  );

  modport slave (
    output full, byte_in,
    input  addr, read, buf_clr, sclk, mosi, cs_n, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/spi_buffer_drain.sv
`default_nettype none
// ============================================================================
//  Module      : spi_buffer_drain
//  Description : Drains a full byte buffer onto SPI (mode 0, MSB first) in one
//                chip-select frame, then requests a buffer clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_buffer_drain #(
  parameter int CLK_DIV = 4,
  parameter int NBYTES  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  spi_buffer_drain_if.master bus
);

  localparam int              DIVW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] c_DIV_LAST  = DIVW'(CLK_DIV - 1);
  localparam logic [DIVW-1:0] c_DIV_ONE   = DIVW'(1);
  localparam logic [4:0]      c_LAST_ADDR = 5'(NBYTES - 1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_FETCH  = 3'd1;
  localparam logic [2:0] c_LATCH  = 3'd2;
  localparam logic [2:0] c_SHIFT  = 3'd3;
  localparam logic [2:0] c_NEXT   = 3'd4;
  localparam logic [2:0] c_FINISH = 3'd5;

  logic [2:0]      r_state,   w_state_nxt;
  logic            r_armed,   w_armed_nxt;
  logic [4:0]      r_addr,    w_addr_nxt;
  logic            r_read,    w_read_nxt;
  logic            r_buf_clr, w_buf_clr_nxt;
  logic            r_sclk,    w_sclk_nxt;
  logic            r_mosi,    w_mosi_nxt;
  logic            r_cs_n,    w_cs_n_nxt;
  logic            r_busy,    w_busy_nxt;
  logic            r_done,    w_done_nxt;
  logic [7:0]      r_shift,   w_shift_nxt;
  logic [DIVW-1:0] r_div,     w_div_nxt;
  logic [2:0]      r_bitcnt,  w_bitcnt_nxt;

  logic w_start;
  logic w_tick;
  logic w_last_fall;
  logic w_last_byte;

  // ARMED guards against restarting on a FULL that was never seen low.
  assign w_start     = bus.full & r_armed;
  assign w_tick      = (r_div == c_DIV_LAST);
  assign w_last_fall = w_tick & r_sclk & (r_bitcnt == 3'd7);
  assign w_last_byte = (r_addr == c_LAST_ADDR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= c_IDLE;
      r_armed   <= 1'b0;
      r_addr    <= '0;
      r_read    <= 1'b0;
      r_buf_clr <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_shift   <= '0;
      r_div     <= '0;
      r_bitcnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_armed   <= w_armed_nxt;
      r_addr    <= w_addr_nxt;
      r_read    <= w_read_nxt;
      r_buf_clr <= w_buf_clr_nxt;
      r_sclk    <= w_sclk_nxt;
      r_mosi    <= w_mosi_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_shift   <= w_shift_nxt;
      r_div     <= w_div_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (w_start) w_state_nxt = c_FETCH;
      c_FETCH:  w_state_nxt = c_LATCH;
      c_LATCH:  w_state_nxt = c_SHIFT;
      c_SHIFT:  if (w_last_fall) w_state_nxt = c_NEXT;
      c_NEXT:   w_state_nxt = w_last_byte ? c_FINISH : c_FETCH;
      c_FINISH: w_state_nxt = c_IDLE;
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_armed_nxt   = r_armed;
    w_addr_nxt    = r_addr;
    w_read_nxt    = 1'b0;
    w_buf_clr_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_sclk_nxt    = r_sclk;
    w_mosi_nxt    = r_mosi;
    w_cs_n_nxt    = r_cs_n;
    w_busy_nxt    = r_busy;
    w_shift_nxt   = r_shift;
    w_div_nxt     = r_div;
    w_bitcnt_nxt  = r_bitcnt;
    case (r_state)
      c_IDLE: begin
        if (!bus.full) w_armed_nxt = 1'b1;
        if (w_start) begin
          w_armed_nxt = 1'b0;
          w_cs_n_nxt  = 1'b0;
          w_addr_nxt  = '0;
          w_read_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      c_LATCH: begin
        w_shift_nxt  = bus.byte_in;
        w_mosi_nxt   = bus.byte_in[7];
        w_div_nxt    = '0;
        w_bitcnt_nxt = '0;
      end
      c_SHIFT: begin
        if (w_tick) begin
          w_div_nxt  = '0;
          w_sclk_nxt = ~r_sclk;
          // Data advances only on the falling edge so the slave sees it settled at the rise.
          if (r_sclk && (r_bitcnt != 3'd7)) begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_shift_nxt  = {r_shift[6:0], 1'b0};
            w_mosi_nxt   = r_shift[6];
          end
        end else begin
          w_div_nxt = r_div + c_DIV_ONE;
        end
      end
      c_NEXT: begin
        if (w_last_byte) begin
          w_cs_n_nxt    = 1'b1;
          w_done_nxt    = 1'b1;
          w_buf_clr_nxt = 1'b1;
          w_mosi_nxt    = 1'b0;
        end else begin
          w_addr_nxt = r_addr + 5'd1;
          w_read_nxt = 1'b1;
        end
      end
      c_FINISH: w_busy_nxt = 1'b0;
      default: ;
    endcase
  end

  assign bus.addr    = r_addr;
  assign bus.read    = r_read;
  assign bus.buf_clr = r_buf_clr;
  assign bus.sclk    = r_sclk;
  assign bus.mosi    = r_mosi;
  assign bus.cs_n    = r_cs_n;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule
`default_nettype wire
